sext_share_arbiter: RTL

- Round-robin arbiter and sequencer sharing one byte-to-word extension datapath (IN_W in, OUT_W out) among NUM_REQ requesters.
- Each requester presents a byte plus a signed/unsigned mode bit.
- The winner's byte is sign- or zero-extended into a single registered output stage with valid/ready flow control and a requester ID tag.
- Sits between byte-producing front ends and the word-wide consumer.

---
 rtl/sext_share_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sext_share_arbiter.sv
// Round-robin arbiter that shares one byte-to-word sign/zero extension stage
// among NUM_REQ requesters, with a single registered valid/ready output slot.
module sext_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IN_W    = 8,
   parameter int OUT_W   = 32,
   parameter int ID_W    = 2,
   parameter int CNT_W   = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*IN_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]      req_signed,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [OUT_W-1:0]        out_data,
   output logic [ID_W-1:0]         out_id,
   output logic [CNT_W-1:0]        xfer_count
);

   localparam int PTR_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("sext_share_arbiter: NUM_REQ must be in 2..8");
   end
   if (OUT_W < IN_W) begin : g_bad_out_w
      $error("sext_share_arbiter: OUT_W must be at least IN_W");
   end
   if (ID_W < PTR_W) begin : g_bad_id_w
      $error("sext_share_arbiter: ID_W too narrow for NUM_REQ");
   end

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   state_e             state_q,      state_d;
   logic [PTR_W-1:0]   last_grant_q, last_grant_d;
   logic               out_valid_q,  out_valid_d;
   logic [OUT_W-1:0]   out_data_q,   out_data_d;
   logic [ID_W-1:0]    out_id_q,     out_id_d;
   logic [CNT_W-1:0]   xfer_count_q, xfer_count_d;

   logic               accept;
   logic               grant;
   logic               grant_found;
   logic [PTR_W-1:0]   grant_idx;
   logic [NUM_REQ-1:0] upper_mask;
   logic [NUM_REQ-1:0] upper_valid;
   logic [NUM_REQ-1:0] candidates;
   logic [NUM_REQ-1:0] grant_onehot;
   logic [IN_W-1:0]    grant_byte;
   logic               grant_signed;
   logic [OUT_W-1:0]   ext_word;

   // Round robin as two fixed-priority passes: first the lanes above
   // last_grant, then wrap around to the full set.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      upper_mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         upper_mask[i] = (PTR_W'(i) > last_grant_q);
      end
      upper_valid = req_valid & upper_mask;
      candidates  = (|upper_valid) ? upper_valid : req_valid;
      grant_found = |req_valid;
      grant_idx   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (candidates[i]) grant_idx = PTR_W'(i);
      end
   end

   always_comb begin
      grant_onehot = '0;
      grant_byte   = '0;
      grant_signed = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == PTR_W'(i)) begin
            grant_onehot[i] = grant_found;
            grant_byte      = req_data[i*IN_W +: IN_W];
            grant_signed    = req_signed[i];
         end
      end
   end

   if (OUT_W > IN_W) begin : g_extend
      assign ext_word = {{(OUT_W-IN_W){grant_signed & grant_byte[IN_W-1]}}, grant_byte};
   end else begin : g_no_extend
      assign ext_word = grant_byte;
   end

   // In FULL the slot frees up exactly when the consumer takes the word.
   assign accept    = (state_q == EMPTY) || out_ready;
   assign grant     = accept && grant_found;
   assign req_ready = (grant && rst_n) ? grant_onehot : '0;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_id_d     = out_id_q;
      xfer_count_d = xfer_count_q;

      if (state_q == FULL && out_ready) begin
         xfer_count_d = xfer_count_q + 1'b1;
      end

      if (grant) begin
         out_data_d   = ext_word;
         out_id_d     = ID_W'(grant_idx);
         last_grant_d = grant_idx;
         out_valid_d  = 1'b1;
         state_d      = FULL;
      end else if (state_q == FULL && out_ready) begin
         out_valid_d = 1'b0;
         state_d     = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= EMPTY;
         last_grant_q <= PTR_W'(NUM_REQ - 1);
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_id_q     <= '0;
         xfer_count_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_id_q     <= out_id_d;
         xfer_count_q <= xfer_count_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_id     = out_id_q;
   assign xfer_count = xfer_count_q;

endmodule
